// File: rtl/fp_fclass_pipe_pkg.sv
// Shared FPU definitions for the non-computational FP pipeline.
//   fp_class_t      : per-operand classification record produced by VX_fp_class
//   FP_NCOMP_*      : op-code encodings for CLASS/EQ/LT/LE/MIN/MAX
//   FCLASS_*        : bit positions inside the 10-bit FCLASS result mask
//   fp_canonical_nan: canonical quiet NaN for a given exponent/mantissa width
package fp_fclass_pipe_pkg;

    typedef struct packed {
        logic is_normal;
        logic is_zero;
        logic is_subnormal;
        logic is_inf;
        logic is_nan;
        logic is_quiet;
        logic is_signaling;
    } fp_class_t;

    localparam logic [2:0] FP_NCOMP_CLASS = 3'd0;
    localparam logic [2:0] FP_NCOMP_EQ    = 3'd1;
    localparam logic [2:0] FP_NCOMP_LT    = 3'd2;
    localparam logic [2:0] FP_NCOMP_LE    = 3'd3;
    localparam logic [2:0] FP_NCOMP_MIN   = 3'd4;
    localparam logic [2:0] FP_NCOMP_MAX   = 3'd5;

    localparam int FCLASS_W         = 10;
    localparam int FCLASS_NEG_INF   = 0;
    localparam int FCLASS_NEG_NORM  = 1;
    localparam int FCLASS_NEG_SUB   = 2;
    localparam int FCLASS_NEG_ZERO  = 3;
    localparam int FCLASS_POS_ZERO  = 4;
    localparam int FCLASS_POS_SUB   = 5;
    localparam int FCLASS_POS_NORM  = 6;
    localparam int FCLASS_POS_INF   = 7;
    localparam int FCLASS_SNAN      = 8;
    localparam int FCLASS_QNAN      = 9;

    // Sign 0, exponent all ones, mantissa MSB set. Returned 64 bits wide so
    // callers can size it to their own FLEN.
    function automatic logic [63:0] fp_canonical_nan(input int exp_bits, input int man_bits);
        logic [63:0] v;
        v = ((64'd1 << exp_bits) - 64'd1) << man_bits;
        v = v | (64'd1 << (man_bits - 1));
        return v;
    endfunction

endpackage

// File: rtl/VX_fp_class.sv
// Per-operand floating-point classifier.
//   exp_i  : biased exponent field
//   man_i  : mantissa (fraction) field
//   clss_o : classification record
module VX_fp_class
    import fp_fclass_pipe_pkg::*;
#(
    parameter int EXP_BITS = 8,
    parameter int MAN_BITS = 23
) (
    input  logic [EXP_BITS-1:0] exp_i,
    input  logic [MAN_BITS-1:0] man_i,
    output fp_class_t           clss_o
);

    logic exp_ones;
    logic exp_zero;
    logic man_zero;

    assign exp_ones = &exp_i;
    assign exp_zero = ~|exp_i;
    assign man_zero = ~|man_i;

    always_comb begin
        clss_o              = '0;
        clss_o.is_normal    = ~exp_zero & ~exp_ones;
        clss_o.is_zero      = exp_zero & man_zero;
        clss_o.is_subnormal = exp_zero & ~man_zero;
        clss_o.is_inf       = exp_ones & man_zero;
        clss_o.is_nan       = exp_ones & ~man_zero;
        // Mantissa MSB distinguishes quiet from signaling NaN.
        clss_o.is_quiet     = exp_ones & ~man_zero & man_i[MAN_BITS-1];
        clss_o.is_signaling = exp_ones & ~man_zero & ~man_i[MAN_BITS-1];
    end

endmodule

// File: rtl/fp_ncomp_lane.sv
// Combinational per-lane compute for CLASS/EQ/LT/LE/MIN/MAX.
//   op_i               : operation code (FP_NCOMP_*)
//   a_i, b_i           : operands
//   a_sign_i, b_sign_i : operand signs
//   a_cls_i, b_cls_i   : operand classification records
//   result_o           : lane result (CLASS/EQ/LT/LE zero-extended)
//   nv_o               : invalid-operation flag
module fp_ncomp_lane
    import fp_fclass_pipe_pkg::*;
#(
    parameter int EXP_BITS = 8,
    parameter int MAN_BITS = 23,
    localparam int FLEN    = 1 + EXP_BITS + MAN_BITS
) (
    input  logic [2:0]      op_i,
    input  logic [FLEN-1:0] a_i,
    input  logic [FLEN-1:0] b_i,
    input  logic            a_sign_i,
    input  logic            b_sign_i,
    input  fp_class_t       a_cls_i,
    input  fp_class_t       b_cls_i,
    output logic [FLEN-1:0] result_o,
    output logic            nv_o
);

    localparam logic [FLEN-1:0] CANON_NAN = FLEN'(fp_canonical_nan(EXP_BITS, MAN_BITS));

    logic [FLEN-2:0]     a_mag;
    logic [FLEN-2:0]     b_mag;
    logic                both_zero;
    logic                any_nan;
    logic                any_snan;
    logic                lt_ord;
    logic                eq_ord;
    logic                min_pick_a;
    logic                max_pick_a;
    logic [FCLASS_W-1:0] cls_mask;

    assign a_mag = a_i[FLEN-2:0];
    assign b_mag = b_i[FLEN-2:0];

    assign both_zero = a_cls_i.is_zero & b_cls_i.is_zero;
    assign any_nan   = a_cls_i.is_nan | b_cls_i.is_nan;
    assign any_snan  = a_cls_i.is_signaling | b_cls_i.is_signaling;
    assign eq_ord    = both_zero | (a_i == b_i);

    // Ordered less-than for non-NaN inputs. Negative magnitudes order in
    // reverse, and +0/-0 compare equal.
    always_comb begin
        lt_ord = 1'b0;
        if (both_zero) begin
            lt_ord = 1'b0;
        end else if (a_sign_i != b_sign_i) begin
            lt_ord = a_sign_i;
        end else if (a_sign_i) begin
            lt_ord = a_mag > b_mag;
        end else begin
            lt_ord = a_mag < b_mag;
        end
    end

    // For the signed-zero pair, MIN prefers the negative zero and MAX the
    // positive one; otherwise the ordering decides.
    assign min_pick_a = both_zero ? a_sign_i  : lt_ord;
    assign max_pick_a = both_zero ? ~a_sign_i : ~lt_ord;

    always_comb begin
        cls_mask = '0;
        if (a_cls_i.is_signaling) begin
            cls_mask[FCLASS_SNAN] = 1'b1;
        end else if (a_cls_i.is_quiet) begin
            cls_mask[FCLASS_QNAN] = 1'b1;
        end else if (a_cls_i.is_inf) begin
            cls_mask[a_sign_i ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
        end else if (a_cls_i.is_normal) begin
            cls_mask[a_sign_i ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
        end else if (a_cls_i.is_subnormal) begin
            cls_mask[a_sign_i ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
        end else begin
            cls_mask[a_sign_i ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
        end
    end

    always_comb begin
        result_o = '0;
        nv_o     = 1'b0;
        case (op_i)
            FP_NCOMP_CLASS: begin
                result_o = {{(FLEN-FCLASS_W){1'b0}}, cls_mask};
            end
            FP_NCOMP_EQ: begin
                result_o = {{(FLEN-1){1'b0}}, ~any_nan & eq_ord};
                nv_o     = any_snan;
            end
            FP_NCOMP_LT: begin
                result_o = {{(FLEN-1){1'b0}}, ~any_nan & lt_ord};
                nv_o     = any_nan;
            end
            FP_NCOMP_LE: begin
                result_o = {{(FLEN-1){1'b0}}, ~any_nan & (lt_ord | eq_ord)};
                nv_o     = any_nan;
            end
            FP_NCOMP_MIN, FP_NCOMP_MAX: begin
                nv_o = any_snan;
                if (a_cls_i.is_nan & b_cls_i.is_nan) begin
                    result_o = CANON_NAN;
                end else if (a_cls_i.is_nan) begin
                    result_o = b_i;
                end else if (b_cls_i.is_nan) begin
                    result_o = a_i;
                end else if (op_i == FP_NCOMP_MIN) begin
                    result_o = min_pick_a ? a_i : b_i;
                end else begin
                    result_o = max_pick_a ? a_i : b_i;
                end
            end
            default: begin
                result_o = '0;
                nv_o     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fp_fclass_pipe.sv
// Two-stage multi-lane pipeline for FCLASS/FEQ/FLT/FLE/FMIN/FMAX.
//   clk, reset_n        : clock, async active-low reset
//   valid_in / ready_in : request handshake
//   op_type, tag_in     : operation code and opaque tag
//   dataa, datab        : per-lane operands, lane i at [i*FLEN +: FLEN]
//   valid_out/ready_out : result handshake
//   result, tag_out     : per-lane result and returned tag
//   fflags_nv           : per-lane invalid-operation flag
// Stage 0 registers operands plus their class records; stage 1 registers
// the lane results. Both stages advance whenever the next one can accept.
module fp_fclass_pipe
    import fp_fclass_pipe_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int EXP_BITS  = 8,
    parameter int MAN_BITS  = 23,
    parameter int TAGW      = 4,
    localparam int FLEN     = 1 + EXP_BITS + MAN_BITS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [2:0]                op_type,
    input  logic [TAGW-1:0]           tag_in,
    input  logic [NUM_LANES*FLEN-1:0] dataa,
    input  logic [NUM_LANES*FLEN-1:0] datab,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [NUM_LANES*FLEN-1:0] result,
    output logic [TAGW-1:0]           tag_out,
    output logic [NUM_LANES-1:0]      fflags_nv
);

    logic s0_en;
    logic s1_en;

    fp_class_t [NUM_LANES-1:0] a_cls_d;
    fp_class_t [NUM_LANES-1:0] b_cls_d;
    logic      [NUM_LANES-1:0] a_sign_d;
    logic      [NUM_LANES-1:0] b_sign_d;

    logic                      s0_valid_q;
    logic [2:0]                s0_op_q;
    logic [TAGW-1:0]           s0_tag_q;
    logic [NUM_LANES*FLEN-1:0] s0_a_q;
    logic [NUM_LANES*FLEN-1:0] s0_b_q;
    logic [NUM_LANES-1:0]      s0_a_sign_q;
    logic [NUM_LANES-1:0]      s0_b_sign_q;
    fp_class_t [NUM_LANES-1:0] s0_a_cls_q;
    fp_class_t [NUM_LANES-1:0] s0_b_cls_q;

    logic [NUM_LANES*FLEN-1:0] s1_result_d;
    logic [NUM_LANES-1:0]      s1_nv_d;

    logic                      s1_valid_q;
    logic [TAGW-1:0]           s1_tag_q;
    logic [NUM_LANES*FLEN-1:0] s1_result_q;
    logic [NUM_LANES-1:0]      s1_nv_q;

    // ready_in depends only on pipeline occupancy and ready_out.
    assign s1_en    = ~s1_valid_q | ready_out;
    assign s0_en    = ~s0_valid_q | s1_en;
    assign ready_in = s0_en;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign a_sign_d[i] = dataa[i*FLEN + FLEN - 1];
        assign b_sign_d[i] = datab[i*FLEN + FLEN - 1];

        VX_fp_class #(
            .EXP_BITS (EXP_BITS),
            .MAN_BITS (MAN_BITS)
        ) u_class_a (
            .exp_i  (dataa[i*FLEN + MAN_BITS +: EXP_BITS]),
            .man_i  (dataa[i*FLEN +: MAN_BITS]),
            .clss_o (a_cls_d[i])
        );

        VX_fp_class #(
            .EXP_BITS (EXP_BITS),
            .MAN_BITS (MAN_BITS)
        ) u_class_b (
            .exp_i  (datab[i*FLEN + MAN_BITS +: EXP_BITS]),
            .man_i  (datab[i*FLEN +: MAN_BITS]),
            .clss_o (b_cls_d[i])
        );

        fp_ncomp_lane #(
            .EXP_BITS (EXP_BITS),
            .MAN_BITS (MAN_BITS)
        ) u_lane (
            .op_i     (s0_op_q),
            .a_i      (s0_a_q[i*FLEN +: FLEN]),
            .b_i      (s0_b_q[i*FLEN +: FLEN]),
            .a_sign_i (s0_a_sign_q[i]),
            .b_sign_i (s0_b_sign_q[i]),
            .a_cls_i  (s0_a_cls_q[i]),
            .b_cls_i  (s0_b_cls_q[i]),
            .result_o (s1_result_d[i*FLEN +: FLEN]),
            .nv_o     (s1_nv_d[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid_q  <= 1'b0;
            s0_op_q     <= '0;
            s0_tag_q    <= '0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s0_a_sign_q <= '0;
            s0_b_sign_q <= '0;
            s0_a_cls_q  <= '0;
            s0_b_cls_q  <= '0;
        end else if (s0_en) begin
            s0_valid_q  <= valid_in;
            s0_op_q     <= op_type;
            s0_tag_q    <= tag_in;
            s0_a_q      <= dataa;
            s0_b_q      <= datab;
            s0_a_sign_q <= a_sign_d;
            s0_b_sign_q <= b_sign_d;
            s0_a_cls_q  <= a_cls_d;
            s0_b_cls_q  <= b_cls_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_result_q <= '0;
            s1_nv_q     <= '0;
        end else if (s1_en) begin
            s1_valid_q  <= s0_valid_q;
            s1_tag_q    <= s0_tag_q;
            s1_result_q <= s1_result_d;
            s1_nv_q     <= s1_nv_d;
        end
    end

    assign valid_out = s1_valid_q;
    assign result    = s1_result_q;
    assign tag_out   = s1_tag_q;
    assign fflags_nv = s1_nv_q;

endmodule
